// File: rtl/line_buffer_3rows.sv
// Two-line raster buffer: emits a {top,mid,bottom} pixel column per window centre (optional LINE_BUFFER_OVF_FLAG_EN adds sticky ovf_o).
// Latency: 1 cycle from accept or flush step to taps/start_o.
// Backpressure: ready_o drops only for the COLS-cycle bottom-border flush; there is no downstream stall.
module line_buffer_3rows #(
  parameter int ROWS = 480,
  parameter int COLS = 640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pixel_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic [7:0] d5_o,
  output logic [7:0] d4_o,
  output logic [7:0] d3_o,
  output logic       start_o,
  output logic       frame_done_o
`ifdef LINE_BUFFER_OVF_FLAG_EN
  ,
  output logic       ovf_o
`endif
);

  localparam int         CW       = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [9:0] LAST_COL = 10'(COLS - 1);
  localparam logic [9:0] LAST_ROW = 10'(ROWS - 1);

  typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;

  state_t        state;
  logic [9:0]    col;
  logic [9:0]    row;
  logic [7:0]    la [COLS];
  logic [7:0]    lb [COLS];
  logic [CW-1:0] idx;
  logic          accept;

  assign idx     = col[CW-1:0];
  assign ready_o = (state != FLUSH);
  assign accept  = valid_i && ready_o;

  // Line storage has no reset; FILL rewrites LA and the row==1 top-tap forcing masks LB.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      la[idx] <= pixel_i;
      if (state == STREAM) lb[idx] <= la[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL;
      col          <= '0;
      row          <= '0;
      d3_o         <= '0;
      d4_o         <= '0;
      d5_o         <= '0;
      start_o      <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      start_o      <= 1'b0;
      frame_done_o <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            if (col == LAST_COL) begin
              col   <= '0;
              row   <= 10'd1;
              state <= STREAM;
            end else begin
              col <= col + 10'd1;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            d3_o    <= pixel_i;
            d4_o    <= la[idx];
            d5_o    <= (row == 10'd1) ? 8'd0 : lb[idx];
            start_o <= 1'b1;
            if (col == LAST_COL) begin
              col <= '0;
              if (row == LAST_ROW) state <= FLUSH;
              else                 row   <= row + 10'd1;
            end else begin
              col <= col + 10'd1;
            end
          end
        end
        FLUSH: begin
          // Bottom border: last input row becomes the centre, nothing below it.
          d3_o    <= 8'd0;
          d4_o    <= la[idx];
          d5_o    <= lb[idx];
          start_o <= 1'b1;
          if (col == LAST_COL) begin
            frame_done_o <= 1'b1;
            col          <= '0;
            row          <= '0;
            state        <= FILL;
          end else begin
            col <= col + 10'd1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef LINE_BUFFER_OVF_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst)                      ovf_o <= 1'b0;
    else if (valid_i && !ready_o) ovf_o <= 1'b1;
  end
`else
  // Pixels offered while ready_o is low are dropped without any indication.
`endif

endmodule

// File: tb/tb_line_buffer_3rows.sv
// Scoreboard bench for line_buffer_3rows: instance a is 3x4, instance b is 2x2.
module tb_line_buffer_3rows;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pix [2];
  logic       vld [2];
  logic       rdy [2];
  logic [7:0] d5 [2];
  logic [7:0] d4 [2];
  logic [7:0] d3 [2];
  logic       st [2];
  logic       fd [2];
`ifdef LINE_BUFFER_OVF_FLAG_EN
  logic       ovf_a;
  logic       ovf_b;
`endif

  logic [24:0] qa [$];
  logic [24:0] qb [$];
  logic [24:0] last [2];
  int          checks = 0;
  int          errors = 0;
  int          last_wait = 0;

  always #5 clk = ~clk;

  line_buffer_3rows #(.ROWS(3), .COLS(4)) dut_a (
    .clk(clk), .rst(rst), .pixel_i(pix[0]), .valid_i(vld[0]), .ready_o(rdy[0]),
    .d5_o(d5[0]), .d4_o(d4[0]), .d3_o(d3[0]), .start_o(st[0]), .frame_done_o(fd[0])
`ifdef LINE_BUFFER_OVF_FLAG_EN
    , .ovf_o(ovf_a)
`endif
  );

  line_buffer_3rows #(.ROWS(2), .COLS(2)) dut_b (
    .clk(clk), .rst(rst), .pixel_i(pix[1]), .valid_i(vld[1]), .ready_o(rdy[1]),
    .d5_o(d5[1]), .d4_o(d4[1]), .d3_o(d3[1]), .start_o(st[1]), .frame_done_o(fd[1])
`ifdef LINE_BUFFER_OVF_FLAG_EN
    , .ovf_o(ovf_b)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pixel value at (r,c) of a 4-wide frame numbered base+1, base+2, ...
  function automatic logic [7:0] pv(input int base, input int r, input int c);
    return 8'(base + r * 4 + c + 1);
  endfunction

  // Expected columns of a 3x4 frame in raster order of window centres; first n only.
  task automatic push_frame(input int base, input int n);
    int k = 0;
    logic [7:0] e5, e4, e3;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        e5 = (r == 0) ? 8'd0 : pv(base, r - 1, c);
        e4 = pv(base, r, c);
        e3 = (r == 2) ? 8'd0 : pv(base, r + 1, c);
        if (k < n) qa.push_back({(r == 2 && c == 3), e5, e4, e3});
        k++;
      end
    end
  endtask

  task automatic mon(input int k);
    logic [24:0] obs;
    logic [24:0] e;
    int          sz;
    obs = {fd[k], d5[k], d4[k], d3[k]};
    sz  = (k == 0) ? qa.size() : qb.size();
    if (rst) begin
      last[k] = '0;
    end else if (st[k]) begin
      if (sz == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: got column %h expected no column", (k == 0) ? "a_extra_col" : "b_extra_col", obs);
      end else begin
        if (k == 0) e = qa.pop_front();
        else        e = qb.pop_front();
        check((k == 0) ? "a_col" : "b_col", 32'(obs), 32'(e));
      end
      last[k] = {1'b0, obs[23:0]};
    end else begin
      check((k == 0) ? "a_hold" : "b_hold", 32'(obs), 32'(last[k]));
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic send(input int k, input logic [7:0] p, input bit hold);
    int n = 0;
    pix[k] = p;
    vld[k] = hold;
    while (!rdy[k] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    last_wait = n;
    if (!rdy[k]) check("ready_timeout", 32'(rdy[k]), 32'd1);
    vld[k] = 1'b1;
    @(posedge clk);
    #1;
    vld[k] = 1'b0;
  endtask

  task automatic send_frame(input int base, input int gap);
    for (int i = 1; i <= 12; i++) begin
      send(0, 8'(base + i), 1'b0);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() + qb.size()) > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(qa.size() + qb.size()), 32'd0);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    for (int k = 0; k < 2; k++)
      check(name, 32'({rdy[k], st[k], fd[k], d5[k], d4[k], d3[k]}), 32'({1'b1, 26'd0}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      pix[k] = '0;
      vld[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst = 1'b0;

    // Continuous frame 1..12
    push_frame(0, 12);
    send_frame(0, 0);
    drain();

    // Same frame with one idle cycle after each pixel
    push_frame(0, 12);
    send_frame(0, 1);
    drain();

    // Back-to-back frames; next frame waits out exactly the 4-cycle flush
    push_frame(0, 12);
    push_frame(100, 12);
    send_frame(0, 0);
    send(0, 8'd101, 1'b0);
    check("flush_ready_low", 32'(last_wait), 32'd4);
    for (int i = 102; i <= 112; i++) send(0, 8'(i), 1'b0);
    drain();

    // Reset after pixel 7 of a frame, then a fresh frame
    push_frame(0, 3);
    for (int i = 1; i <= 7; i++) send(0, 8'(i), 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_frame(0, 12);
    send_frame(0, 0);
    drain();

    // 2x2 frame, hand-computed columns
    qb.push_back({1'b0, 8'd0, 8'd1, 8'd3});
    qb.push_back({1'b0, 8'd0, 8'd2, 8'd4});
    qb.push_back({1'b0, 8'd1, 8'd3, 8'd0});
    qb.push_back({1'b1, 8'd2, 8'd4, 8'd0});
    for (int i = 1; i <= 4; i++) send(1, 8'(i), 1'b0);
    drain();

`ifdef LINE_BUFFER_OVF_FLAG_EN
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_frame(0, 12);
    push_frame(100, 12);
    send_frame(0, 0);
    check("ovf_before_flush", 32'(ovf_a), 32'd0);
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    check("ovf_first_flush", 32'(ovf_a), 32'd1);
    for (int i = 101; i <= 112; i++) send(0, 8'(i), 1'b1);
    check("ovf_sticky", 32'(ovf_a), 32'd1);
    drain();
    check("ovf_sticky_idle", 32'(ovf_a), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ovf_cleared", 32'(ovf_a), 32'd0);
    rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
